// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_acc_8bits multiply-accumulate back end.
// Clamp-limit helpers are consumed by mac_sat_add when MAC_SAT_EN is defined.
package mac_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Limits are returned in the low w bits of a 64-bit word; callers truncate.
    function automatic logic [63:0] smax_lim(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin_lim(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] umax_lim(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/mac_acc_8bits_if.sv
// Product-in / result-out bus of mac_acc_8bits.
// Handshakes: a beat moves when In_valid && In_ready on a rising clk; a result
// moves when Out_valid && Out_ready. A source holding valid keeps its data
// stable until the transfer; ready never depends combinationally on valid.
interface mac_acc_8bits_if
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
);
    logic [15:0]      Prod;
    logic             Signed;
    logic [LEN_W-1:0] Len;
    logic             In_valid;
    logic             In_ready;
    logic             Clear;
    logic             Out_valid;
    logic             Out_ready;
    logic [ACC_W-1:0] Acc;
    logic             Ovf;

    modport master (
        output Prod, Signed, Len, In_valid, Clear, Out_ready,
        input  In_ready, Out_valid, Acc, Ovf
    );

    modport slave (
        input  Prod, Signed, Len, In_valid, Clear, Out_ready,
        output In_ready, Out_valid, Acc, Ovf
    );
endinterface

// File: rtl/mac_acc_8bits_sat_add.sv
// ACC_W adder with signed/unsigned overflow detection; returns the next sticky
// overflow flag. With MAC_SAT_EN defined the sum clamps and stays clamped.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             mode,
    input  logic             ovf_in,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    logic [ACC_W:0] raw;
    logic           pos_ovf;
    logic           neg_ovf;
    logic           u_ovf;

    always_comb begin
        raw     = {1'b0, a} + {1'b0, b};
        pos_ovf = mode & ~a[ACC_W-1] & ~b[ACC_W-1] &  raw[ACC_W-1];
        neg_ovf = mode &  a[ACC_W-1] &  b[ACC_W-1] & ~raw[ACC_W-1];
        u_ovf   = ~mode & raw[ACC_W];
        ovf     = ovf_in | pos_ovf | neg_ovf | u_ovf;
`ifdef MAC_SAT_EN
        // Once a run has overflowed, the accumulator already sits at a limit.
        if (ovf_in)       sum = a;
        else if (pos_ovf) sum = ACC_W'(smax_lim(ACC_W));
        else if (neg_ovf) sum = ACC_W'(smin_lim(ACC_W));
        else if (u_ovf)   sum = ACC_W'(umax_lim(ACC_W));
        else              sum = raw[ACC_W-1:0];
`else
        sum = raw[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/mac_acc_8bits.sv
// Multiply-accumulate back end: sums Len products from mul_8bits into one result.
// Optional clamp-on-overflow build: define MAC_SAT_EN.
module mac_acc_8bits
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_acc_8bits_if.slave        bus,
    output state_e                dbg_state
);
    state_e           state;
    logic             mode_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic             accept;
    logic             first;
    logic             eff_mode;
    logic [ACC_W-1:0] ext_prod;
    logic [ACC_W-1:0] add_a;
    logic             add_ovf_in;
    logic [ACC_W-1:0] sum;
    logic             ovf_nxt;
    logic [LEN_W-1:0] len_in;
    logic [LEN_W-1:0] cnt_nxt;

    assign bus.In_ready  = (state != HOLD);
    assign bus.Out_valid = out_valid_q;
    assign bus.Acc       = acc_q;
    assign bus.Ovf       = ovf_q;
    assign dbg_state     = state;

    assign accept   = bus.In_valid && bus.In_ready;
    assign first    = (state == IDLE);
    assign eff_mode = first ? bus.Signed : mode_q;
    assign ext_prod = eff_mode ? {{(ACC_W-16){bus.Prod[15]}}, bus.Prod}
                               : {{(ACC_W-16){1'b0}}, bus.Prod};
    // The first beat starts from zero so it never overflows and clears Ovf.
    assign add_a      = first ? '0 : acc_q;
    assign add_ovf_in = first ? 1'b0 : ovf_q;
    assign len_in     = (bus.Len == '0) ? LEN_W'(1) : bus.Len;
    assign cnt_nxt    = cnt + LEN_W'(1);

    mac_sat_add #(.ACC_W(ACC_W)) u_add (
        .a      (add_a),
        .b      (ext_prod),
        .mode   (eff_mode),
        .ovf_in (add_ovf_in),
        .sum    (sum),
        .ovf    (ovf_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            len_q       <= '0;
            cnt         <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.Clear) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q <= bus.Signed;
                        len_q  <= len_in;
                        cnt    <= LEN_W'(1);
                        acc_q  <= sum;
                        ovf_q  <= ovf_nxt;
                        if (len_in == LEN_W'(1)) begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= sum;
                        ovf_q <= ovf_nxt;
                        cnt   <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.Out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
